// File: rtl/minibus_pkg.sv
// minibus_pkg: shared widths, width-code and FSM enums, bus request/response structs
package minibus_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 12;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} width_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    width_e width;
    logic wen;
    logic ren;
  } req_t;
  typedef struct packed {
    logic ack;
    logic err;
    logic [DATA_WIDTH-1:0] rdata;
  } res_t;
endpackage

// File: rtl/minibus_slave_if.sv
// minibus_slave_if: minibus request/response bundle
// clk, nrst: bus clock/reset (informational); sel, req: from master; res: from slave
interface minibus_slave_if (input logic clk, input logic nrst);
  import minibus_pkg::*;
  logic sel;
  req_t req;
  res_t res;
  modport slave (input clk, nrst, sel, req, output res);
  modport master (input clk, nrst, res, output sel, req);
endinterface

// File: rtl/minibus_wdata_merge.sv
// minibus_wdata_merge: places byte/half write data into its lane(s) and checks alignment
// offset/width/wdata: access descriptor; cur: current register word
// merged: cur with written lanes replaced; wbits: written bits only; misaligned: bad width/offset
module minibus_wdata_merge import minibus_pkg::*; (
  input  logic [1:0]            offset,
  input  width_e                width,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] cur,
  output logic [DATA_WIDTH-1:0] merged,
  output logic [DATA_WIDTH-1:0] wbits,
  output logic                  misaligned
);
  localparam logic [DATA_WIDTH-1:0] BM = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] HM = DATA_WIDTH'(16'hFFFF);
  logic [DATA_WIDTH-1:0] lmask;
  always_comb begin
    misaligned = width == HALF ? offset[0] : width == WORD ? |offset : width != BYTE;
    lmask = width == BYTE ? BM << {offset, 3'b000} : width == HALF ? HM << {offset, 3'b000} : '1;
    wbits = (width == WORD ? wdata : wdata << {offset, 3'b000}) & lmask;
    merged = (cur & ~lmask) | wbits;
  end
endmodule

// File: rtl/minibus_slave_regfile.sv
// minibus_slave_regfile: minibus slave register file with RO/W1C bits and hw load ports
// clk/rst: clock, async active-high reset; _slaveif: bus slave port
// hw_we/hw_wdata: per-register hw load; outputs: register contents; wr_pulse: per-register commit pulse
// Define MINIBUS_REGFILE_W1C_EN to honour W1C_MASK; otherwise those bits are plain read/write.
module minibus_slave_regfile import minibus_pkg::*; #(
  parameter int REGS_COUNT = 8,
  parameter int WAIT_CYCLES = 0,
  parameter logic [REGS_COUNT-1:0][DATA_WIDTH-1:0] RO_MASK = '0,
  parameter logic [REGS_COUNT-1:0][DATA_WIDTH-1:0] W1C_MASK = '0,
  parameter logic [REGS_COUNT-1:0][DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  minibus_slave_if.slave                        _slaveif,
  input  logic [REGS_COUNT-1:0]                 hw_we,
  input  logic [REGS_COUNT-1:0][DATA_WIDTH-1:0] hw_wdata,
  output logic [REGS_COUNT-1:0][DATA_WIDTH-1:0] outputs,
  output logic [REGS_COUNT-1:0]                 wr_pulse
);
`ifdef MINIBUS_REGFILE_W1C_EN
  localparam logic [REGS_COUNT-1:0][DATA_WIDTH-1:0] W1C = W1C_MASK & ~RO_MASK;
`else
  localparam logic [REGS_COUNT-1:0][DATA_WIDTH-1:0] W1C = W1C_MASK & '0;
`endif
  state_e state, state_n;
  logic [3:0] cnt;
  req_t q, src;
  res_t res, res_n;
  logic [REGS_COUNT-1:0][DATA_WIDTH-1:0] regs, regs_n;
  logic [REGS_COUNT-1:0] hit, commit;
  logic [DATA_WIDTH-1:0] cur, merged, wbits;
  logic misaligned, err, accept;
  // In IDLE the live request is decoded so a zero-wait response can be formed at the accept edge.
  assign src = state == IDLE ? _slaveif.req : q;
  assign accept = state == IDLE && _slaveif.sel && (_slaveif.req.wen || _slaveif.req.ren);
  assign outputs = regs;
  assign _slaveif.res = res;
  minibus_wdata_merge u_merge (
    .offset(src.addr[1:0]), .width(src.width), .wdata(src.wdata), .cur(cur),
    .merged(merged), .wbits(wbits), .misaligned(misaligned)
  );
  always_comb begin
    hit = '0;
    cur = '0;
    for (int i = 0; i < REGS_COUNT; i++) begin
      hit[i] = src.addr[ADDR_WIDTH-1:2] == (ADDR_WIDTH-2)'(i);
      cur = cur | (hit[i] ? regs[i] : '0);
    end
    err = misaligned || !(|hit) || (src.wen && src.ren);
    commit = state == RESP && q.wen && !err ? hit : '0;
    state_n = state == IDLE ? (accept ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE) :
              state == WAIT ? (cnt == 4'(WAIT_CYCLES - 1) ? RESP : WAIT) : IDLE;
    res_n = state_n == RESP ? {1'b1, err, src.ren && !err ? cur : DATA_WIDTH'(0)} : '0;
  end
  // Bus value keeps RO bits, clears W1C bits written with 1; hw wins only on RO/W1C bits.
  always_comb begin
    logic [DATA_WIDTH-1:0] bus, keep;
    regs_n = regs;
    for (int i = 0; i < REGS_COUNT; i++) begin
      keep = RO_MASK[i] | W1C[i];
      bus = (regs[i] & RO_MASK[i]) | (regs[i] & W1C[i] & ~wbits) | (merged & ~keep);
      regs_n[i] = hw_we[i] ? (hw_wdata[i] & keep) | ((commit[i] ? bus : hw_wdata[i]) & ~keep) :
                  commit[i] ? bus : regs[i];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      q <= '0;
      res <= '0;
      regs <= RESET_VAL;
      wr_pulse <= '0;
    end else begin
      state <= state_n;
      cnt <= state == WAIT ? cnt + 4'd1 : '0;
      if (accept) q <= _slaveif.req;
      res <= res_n;
      regs <= regs_n;
      wr_pulse <= commit;
    end
endmodule

// File: tb/tb_minibus_slave_regfile.sv
// tb_minibus_slave_regfile: directed checks of two regfile instances (zero-wait and 3-wait)
module tb_minibus_slave_regfile;
  import minibus_pkg::*;
  localparam int N = 8;
  localparam logic [N-1:0][31:0] RST_A = {32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h11223344, 32'h0, 32'h0};
  localparam logic [N-1:0][31:0] RO_A  = {32'h0, 32'h0, 32'h0000FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [N-1:0][31:0] W1C_A = {32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [N-1:0][31:0] RST_B = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h100, 32'h5};
`ifdef MINIBUS_REGFILE_W1C_EN
  localparam logic [31:0] W1C_EXP = 32'hF0;
`else
  localparam logic [31:0] W1C_EXP = 32'h0F;
`endif
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N-1:0] hwe_a = '0, hwe_b = '0, pul_a, pul_b;
  logic [N-1:0][31:0] hwd_a = '0, hwd_b = '0, out_a, out_b;
  minibus_slave_if ifa (.clk(clk), .nrst(!rst));
  minibus_slave_if ifb (.clk(clk), .nrst(!rst));
  minibus_slave_regfile #(.REGS_COUNT(N), .WAIT_CYCLES(0), .RO_MASK(RO_A), .W1C_MASK(W1C_A), .RESET_VAL(RST_A)) dut_a (
    .clk(clk), .rst(rst), ._slaveif(ifa), .hw_we(hwe_a), .hw_wdata(hwd_a), .outputs(out_a), .wr_pulse(pul_a));
  minibus_slave_regfile #(.REGS_COUNT(N), .WAIT_CYCLES(3), .RESET_VAL(RST_B)) dut_b (
    .clk(clk), .rst(rst), ._slaveif(ifb), .hw_we(hwe_b), .hw_wdata(hwd_b), .outputs(out_b), .wr_pulse(pul_b));
  int nvec = 0, nerr = 0, lat;
  res_t got, tmp;
  logic ack2;
  logic [N-1:0] p1, p2, hw_resp = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic txn(input bit b, input logic [11:0] a, input logic [31:0] wd, input width_e w, input logic we, input logic re);
    req_t r;
    r = '{addr: a, wdata: wd, width: w, wen: we, ren: re};
    @(negedge clk);
    if (b) begin ifb.sel = 1; ifb.req = r; end else begin ifa.sel = 1; ifa.req = r; end
    @(posedge clk);
    #1;
    if (b) begin ifb.sel = 0; ifb.req = req_t'(~r); end else begin ifa.sel = 0; ifa.req = req_t'(~r); end
    lat = 0;
    got = '0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      got = b ? ifb.res : ifa.res;
      if (got.ack) begin
        lat = i;
        if (!b) hwe_a = hw_resp;
      end
    end
    @(negedge clk);
    hwe_a = '0;
    hw_resp = '0;
    tmp = b ? ifb.res : ifa.res;
    ack2 = tmp.ack;
    p1 = b ? pul_b : pul_a;
    @(negedge clk);
    p2 = b ? pul_b : pul_a;
    if (b) ifb.req = '0; else ifa.req = '0;
  endtask
  initial begin
    ifa.sel = 0; ifa.req = '0; ifb.sel = 0; ifb.req = '0;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_a_reg", out_a[i], RST_A[i]);
      chk("rst_b_reg", out_b[i], RST_B[i]);
    end
    chk("rst_res", {ifa.res.ack, ifb.res.ack}, 0);
    chk("rst_pulse", {pul_a, pul_b}, 0);
    rst = 0;
    txn(0, 12'h4, 32'hDEADBEEF, WORD, 1, 0);
    chk("w0_lat", lat, 1); chk("w0_err", got.err, 0); chk("w0_ack_once", ack2, 0);
    chk("w0_reg1", out_a[1], 32'hDEADBEEF); chk("w0_pulse", p1, 8'h02); chk("w0_pulse_end", p2, 0);
    txn(0, 12'hA, 32'hAA, BYTE, 1, 0);
    chk("byte_reg2", out_a[2], 32'h11AA3344); chk("byte_pulse", p1, 8'h04);
    txn(0, 12'h9, 32'hFFFF, HALF, 1, 0);
    chk("half_odd_err", got.err, 1); chk("half_odd_reg2", out_a[2], 32'h11AA3344); chk("half_odd_pulse", p1, 0);
    txn(0, 12'h8, 32'h0, WORD, 0, 1);
    chk("rd2_lat", lat, 1); chk("rd2_err", got.err, 0); chk("rd2_data", got.rdata, 32'h11AA3344);
    txn(0, 12'h20, 32'h0, WORD, 0, 1);
    chk("rd_oor_err", got.err, 1); chk("rd_oor_data", got.rdata, 0);
    txn(0, 12'h8, 32'h0, width_e'(2'b11), 0, 1);
    chk("w11_err", got.err, 1); chk("w11_data", got.rdata, 0);
    txn(0, 12'h6, 32'h55, WORD, 1, 0);
    chk("word_mis_err", got.err, 1); chk("word_mis_reg1", out_a[1], 32'hDEADBEEF);
    txn(0, 12'h4, 32'h1, WORD, 1, 1);
    chk("both_err", got.err, 1); chk("both_data", got.rdata, 0);
    chk("both_reg1", out_a[1], 32'hDEADBEEF); chk("both_pulse", p1, 0);
    txn(0, 12'hE, 32'hCAFE, HALF, 1, 0);
    chk("half_hi_reg3", out_a[3], 32'hCAFE0000);
    txn(0, 12'h14, 32'hFFFFFFFF, WORD, 1, 0);
    chk("ro_reg5", out_a[5], 32'hFFFF0000);
    txn(0, 12'h18, 32'h0F, WORD, 1, 0);
    chk("w1c_reg6", out_a[6], W1C_EXP);
    hwd_a[3] = 32'h1; hw_resp = 8'h08;
    txn(0, 12'hC, 32'h2, WORD, 1, 0);
    chk("hw_bus_rw_reg3", out_a[3], 32'h2);
    hwd_a[5] = 32'h12345678; hw_resp = 8'h20;
    txn(0, 12'h14, 32'hAAAAAAAA, WORD, 1, 0);
    chk("hw_bus_ro_reg5", out_a[5], 32'hAAAA5678);
    @(negedge clk); hwe_a[7] = 1; hwd_a[7] = 32'h1234;
    @(negedge clk); hwe_a = '0;
    chk("hw_only_reg7", out_a[7], 32'h1234);
    txn(1, 12'h0, 32'h0, WORD, 0, 1);
    chk("b_rd_lat", lat, 4); chk("b_rd_data", got.rdata, 32'h5); chk("b_rd_err", got.err, 0); chk("b_ack_once", ack2, 0);
    txn(1, 12'h4, 32'h33, WORD, 1, 0);
    chk("b_wr_lat", lat, 4); chk("b_wr_reg1", out_b[1], 32'h33); chk("b_wr_pulse", p1, 8'h02);
    @(negedge clk); hwe_b[2] = 1; hwd_b[2] = 32'h77;
    @(negedge clk); hwe_b = '0;
    chk("b_hw_reg2", out_b[2], 32'h77);
    ifb.sel = 1; ifb.req = '{addr: 12'h0, wdata: 32'h99, width: WORD, wen: 1'b1, ren: 1'b0};
    @(posedge clk); #1;
    ifb.sel = 0; ifb.req = '0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    lat = 0;
    p1 = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifb.res.ack) lat++;
      p1 = p1 | pul_b;
    end
    chk("rst_wait_ack", lat, 0); chk("rst_wait_pulse", p1, 0);
    for (int i = 0; i < N; i++) chk("rst_wait_reg", out_b[i], RST_B[i]);
    chk("rst_a_reg1", out_a[1], 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
